// File: rtl/keypad_pkg.sv
// ============================================================================
//  Module   : keypad_pkg
//  Purpose  : Shared types and constants for the keypad entry controller:
//             the key-scan FSM state enum and digit-buffer geometry.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

  localparam int NDIGITS = 8;   // digit buffer depth
  localparam int DIGIT_W = 4;   // one hex digit

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/key_prienc.sv
// ============================================================================
//  Module   : key_prienc
//  Purpose  : 16-to-4 priority encoder; the highest set input index wins.
//  Ports    : in[15:0]  - synchronized key levels
//             code[3:0] - index of the highest set bit (0 when none set)
//             valid     - any bit of in is set
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_prienc (
  input  logic [15:0] in,
  output logic [3:0]  code,
  output logic        valid
);

  always_comb begin
    code  = 4'h0;
    valid = |in;
    // Ascending scan: a later (higher) set bit overwrites a lower one.
    for (int i = 0; i < 16; i++) begin
      if (in[i]) code = 4'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/keypad_entry_ctrl.sv
// ============================================================================
//  Module   : keypad_entry_ctrl
//  Purpose  : Hex keypad front end. Synchronizes raw key levels, priority
//             encodes them, debounces press/release with an FSM and shifts
//             accepted digits into an eight-digit entry buffer with clear
//             and backspace.
//  Ports    : hz100      - clock (rising edge)
//             reset      - asynchronous active-low reset
//             key[15:0]  - raw push-button levels, bit i = hex digit i
//             clr        - pulse, empties the digit buffer
//             bksp       - pulse, removes the newest digit
//             key_code   - code of the last accepted key
//             key_strobe - one-cycle pulse per accepted key event
//             digits     - eight packed digits, [3:0] newest
//             ndigits    - number of valid digits (0..8)
//             full       - ndigits == 8
//             overflow   - pulse when a key is accepted while full
//  Options  : KEYPAD_AUTOREPEAT_EN - when defined, a held key re-accepts
//             every REPEAT_CYC cycles.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 3,
  parameter int REPEAT_CYC   = 50
) (
  input  logic        hz100,
  input  logic        reset,
  input  logic [15:0] key,
  input  logic        clr,
  input  logic        bksp,
  output logic [3:0]  key_code,
  output logic        key_strobe,
  output logic [31:0] digits,
  output logic [3:0]  ndigits,
  output logic        full,
  output logic        overflow
);

  localparam int c_buf_w = NDIGITS * DIGIT_W;
  localparam int c_db_w  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  if (DEBOUNCE_CYC < 1 || REPEAT_CYC < 1) begin : g_param_check
    $error("keypad_entry_ctrl: DEBOUNCE_CYC and REPEAT_CYC must be >= 1");
  end

  // 2-flop synchronizer on the raw key levels
  logic [15:0] r_sync1;
  logic [15:0] r_sync2;

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= key;
      r_sync2 <= r_sync1;
    end
  end

  logic [3:0] w_code;
  logic       w_valid;

  key_prienc u_prienc (
    .in    (r_sync2),
    .code  (w_code),
    .valid (w_valid)
  );

  state_t              r_state;
  logic [3:0]          r_cand;      // candidate code, frozen once HELD
  logic [c_db_w-1:0]   r_db_cnt;
  logic [3:0]          r_key_code;
  logic                r_strobe;

  logic w_db_done;
  logic w_repeat;
  logic w_accept;

  assign w_db_done = (r_state == DEBOUNCE) && w_valid && (w_code == r_cand) &&
                     (r_db_cnt == c_db_w'(DEBOUNCE_CYC - 1));

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int c_rep_w = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
  logic [c_rep_w-1:0] r_rep_cnt;
  assign w_repeat = (r_state == HELD) && w_valid &&
                    (r_rep_cnt == c_rep_w'(REPEAT_CYC - 1));
`else
  assign w_repeat = 1'b0;
`endif

  // One acceptance event; drives both the strobe register and the buffer.
  assign w_accept = w_db_done || w_repeat;

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cand     <= 4'h0;
      r_db_cnt   <= '0;
      r_key_code <= 4'h0;
      r_strobe   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      r_rep_cnt  <= '0;
`endif
    end else begin
      r_strobe <= w_accept;
      if (w_accept) r_key_code <= r_cand;

      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_state  <= DEBOUNCE;
            r_cand   <= w_code;
            r_db_cnt <= '0;
          end
        end
        DEBOUNCE: begin
          if (!w_valid) begin
            r_state  <= IDLE;
            r_db_cnt <= '0;
          end else if (w_code != r_cand) begin
            r_cand   <= w_code;
            r_db_cnt <= '0;
          end else if (w_db_done) begin
            r_state  <= HELD;
            r_db_cnt <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            r_rep_cnt <= '0;
`endif
          end else begin
            r_db_cnt <= r_db_cnt + c_db_w'(1);
          end
        end
        HELD: begin
          // A different code while held is ignored; only loss of valid counts.
          if (!w_valid) begin
            r_state  <= RELEASE;
            r_db_cnt <= '0;
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (w_repeat) r_rep_cnt <= '0;
          else               r_rep_cnt <= r_rep_cnt + c_rep_w'(1);
`endif
        end
        RELEASE: begin
          if (w_valid) begin
            // Release bounce: resume holding without a new strobe.
            r_state  <= HELD;
            r_db_cnt <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            r_rep_cnt <= '0;
`endif
          end else if (r_db_cnt == c_db_w'(DEBOUNCE_CYC - 1)) begin
            r_state  <= IDLE;
            r_db_cnt <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + c_db_w'(1);
          end
        end
        default: begin
          r_state  <= IDLE;
          r_db_cnt <= '0;
        end
      endcase
    end
  end

  // Digit buffer: clr beats bksp beats acceptance.
  logic [c_buf_w-1:0] r_digits;
  logic [3:0]         r_ndigits;
  logic               r_overflow;
  logic               w_full;

  assign w_full = (r_ndigits == 4'(NDIGITS));

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      r_digits   <= '0;
      r_ndigits  <= 4'h0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_accept && w_full;
      if (clr) begin
        r_digits  <= '0;
        r_ndigits <= 4'h0;
      end else if (bksp) begin
        if (r_ndigits != 4'h0) begin
          r_digits  <= {{DIGIT_W{1'b0}}, r_digits[c_buf_w-1:DIGIT_W]};
          r_ndigits <= r_ndigits - 4'h1;
        end
      end else if (w_accept && !w_full) begin
        r_digits  <= {r_digits[c_buf_w-DIGIT_W-1:0], r_cand};
        r_ndigits <= r_ndigits + 4'h1;
      end
    end
  end

  assign key_code   = r_key_code;
  assign key_strobe = r_strobe;
  assign digits     = r_digits;
  assign ndigits    = r_ndigits;
  assign full       = w_full;
  assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_keypad_entry_ctrl.sv
// ============================================================================
//  Module   : tb_keypad_entry_ctrl
//  Purpose  : Self-checking bench for keypad_entry_ctrl. A behavioural model
//             (run-length debounce, digit queue) is compared every cycle;
//             directed scenarios pin literal expectations.
//  Options  : KEYPAD_AUTOREPEAT_EN enables the auto-repeat scenario.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_entry_ctrl;

  localparam int D = 3;
  localparam int R = 50;

  logic        hz100 = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] key   = 16'h0;
  logic        clr   = 1'b0;
  logic        bksp  = 1'b0;
  logic [3:0]  key_code;
  logic        key_strobe;
  logic [31:0] digits;
  logic [3:0]  ndigits;
  logic        full;
  logic        overflow;

  always #5 hz100 = ~hz100;

  keypad_entry_ctrl #(.DEBOUNCE_CYC(D), .REPEAT_CYC(R)) dut (
    .hz100      (hz100),
    .reset      (reset),
    .key        (key),
    .clr        (clr),
    .bksp       (bksp),
    .key_code   (key_code),
    .key_strobe (key_strobe),
    .digits     (digits),
    .ndigits    (ndigits),
    .full       (full),
    .overflow   (overflow)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_s1 = 16'h0, m_s2 = 16'h0;   // two-cycle input delay
  int          run = 0;                      // consecutive equal valid codes
  logic [3:0]  run_code = 4'h0;
  bit          pressed = 1'b0;
  logic [3:0]  held_code = 4'h0;
  int          lowrun = 0;
  int          heldrun = 0;
  logic        m_strobe = 1'b0, m_ovf = 1'b0;
  logic [3:0]  m_code = 4'h0;
  logic [3:0]  mq[$];                        // mq[0] is the newest digit

  function automatic logic [3:0] top_bit(input logic [15:0] v);
    for (int i = 15; i >= 0; i--) if (v[i]) return 4'(i);
    return 4'h0;
  endfunction

  always @(posedge hz100 or negedge reset) begin : model
    bit         v;
    logic [3:0] c;
    bit         acc;
    if (!reset) begin
      m_s1 = 16'h0; m_s2 = 16'h0; run = 0; run_code = 4'h0; pressed = 1'b0;
      held_code = 4'h0; lowrun = 0; heldrun = 0; m_strobe = 1'b0; m_ovf = 1'b0;
      m_code = 4'h0; mq.delete();
    end else begin
      v   = (m_s2 != 16'h0);
      c   = top_bit(m_s2);
      acc = 1'b0;
      if (!pressed) begin
        if (v) begin
          if (run > 0 && c == run_code) run++;
          else begin run = 1; run_code = c; end
        end else run = 0;
        // Stable from edge k -> strobe at k+2+D: D+1 equal samples.
        if (run == D + 1) begin
          acc = 1'b1; pressed = 1'b1; held_code = run_code;
          lowrun = 0; heldrun = 0;
        end
      end else begin
        if (!v) begin
          lowrun++; heldrun = 0;
          if (lowrun == D + 1) begin pressed = 1'b0; run = 0; lowrun = 0; end
        end else if (lowrun > 0) begin
          lowrun = 0; heldrun = 0;
        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
          heldrun++;
          if (heldrun == R) begin acc = 1'b1; heldrun = 0; end
`endif
        end
      end
      m_strobe = acc;
      m_ovf    = acc && (mq.size() == 8);
      if (acc) m_code = held_code;
      if (clr) mq.delete();
      else if (bksp) begin
        if (mq.size() > 0) void'(mq.pop_front());
      end else if (acc && mq.size() < 8) mq.push_front(held_code);
      m_s2 = m_s1;
      m_s1 = key;
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge hz100) begin
    if (cmp_en) begin
      logic [31:0] d;
      d = 32'h0;
      for (int i = 0; i < mq.size(); i++) d = d | (32'(mq[i]) << (4 * i));
      chk("key_strobe", 32'(key_strobe), 32'(m_strobe));
      chk("key_code",   32'(key_code),   32'(m_code));
      chk("overflow",   32'(overflow),   32'(m_ovf));
      chk("digits",     digits,          d);
      chk("ndigits",    32'(ndigits),    32'(mq.size()));
      chk("full",       32'(full),       32'(mq.size() == 8));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge hz100);
    #2;
  endtask

  task automatic press(input logic [15:0] k, input int hold, output int nstb, output int first);
    key = k; nstb = 0; first = -1;
    for (int i = 0; i < hold; i++) begin
      step();
      if (key_strobe) begin nstb++; if (first < 0) first = i; end
    end
    key = 16'h0;
    repeat (D + 4) step();
  endtask

  initial begin
    int n, f, novf, hold;
    int idx[$];
    #1 reset = 1'b0;
    cmp_en = 1'b1;
    repeat (3) step();
    chk("rst_strobe", 32'(key_strobe), 32'h0);
    chk("rst_digits", digits, 32'h0);
    chk("rst_ndigits", 32'(ndigits), 32'h0);
    chk("rst_code", 32'(key_code), 32'h0);
    reset = 1'b1;
    step();

    // Single key, strobe latency
    press(16'h0020, 10, n, f);
    chk("k5_nstrobe", n, 1);
    chk("k5_cycle", f, 5);
    chk("k5_code", 32'(key_code), 32'h5);
    chk("k5_digits", digits, 32'h0000_0005);
    chk("k5_ndigits", 32'(ndigits), 32'h1);

    // Multi-key priority and a one-cycle glitch during debounce
    n = 0; f = -1;
    for (int i = 0; i < 16; i++) begin
      key = (i == 3) ? 16'h0041 : 16'h8041;
      step();
      if (key_strobe) begin n++; if (f < 0) f = i; end
    end
    key = 16'h0;
    repeat (D + 4) step();
    chk("glitch_nstrobe", n, 1);
    chk("glitch_cycle", f, 9);
    chk("glitch_code", 32'(key_code), 32'hF);

    // Fill to eight digits, then overflow
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_ndigits", 32'(ndigits), 32'h0);
    for (int d = 1; d <= 8; d++) press(16'(1 << d), 6, n, f);
    chk("fill_digits", digits, 32'h1234_5678);
    chk("fill_full", 32'(full), 32'h1);
    key = 16'h0200; novf = 0; n = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (key_strobe) n++;
      if (overflow) begin novf++; chk("ovf_with_strobe", 32'(key_strobe), 32'h1); end
    end
    key = 16'h0; repeat (D + 4) step();
    chk("ovf_count", novf, 1);
    chk("ovf_strobes", n, 1);
    chk("ovf_digits", digits, 32'h1234_5678);

    // Backspace, then clr colliding with an acceptance
    bksp = 1'b1; step(); bksp = 1'b0;
    chk("bksp_digits", digits, 32'h0123_4567);
    chk("bksp_ndigits", 32'(ndigits), 32'h7);
    key = 16'h0010;
    repeat (5) step();
    clr = 1'b1; step(); clr = 1'b0;
    chk("clracc_strobe", 32'(key_strobe), 32'h1);
    chk("clracc_digits", digits, 32'h0);
    chk("clracc_ndigits", 32'(ndigits), 32'h0);
    key = 16'h0; repeat (D + 4) step();

    // Release bounce returns to holding without a second strobe
    key = 16'h0008; n = 0;
    for (int i = 0; i < 8; i++) begin step(); if (key_strobe) n++; end
    key = 16'h0; step(); if (key_strobe) n++;
    key = 16'h0008;
    for (int i = 0; i < 10; i++) begin step(); if (key_strobe) n++; end
    key = 16'h0; repeat (D + 4) step();
    chk("bounce_nstrobe", n, 1);
    chk("bounce_digits", digits, 32'h3);

    // Reset mid-press aborts, key re-debounces afterwards
    key = 16'h0100;
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk("midrst_strobe", 32'(key_strobe), 32'h0);
    chk("midrst_digits", digits, 32'h0);
    step(); step();
    reset = 1'b1; n = 0;
    for (int i = 0; i < 10; i++) begin step(); if (key_strobe) n++; end
    key = 16'h0; repeat (D + 4) step();
    chk("midrst_nstrobe", n, 1);
    chk("midrst_code", 32'(key_code), 32'h8);

`ifdef KEYPAD_AUTOREPEAT_EN
    clr = 1'b1; step(); clr = 1'b0;
    key = 16'h0004;
    for (int i = 0; i < 120; i++) begin step(); if (key_strobe) idx.push_back(i); end
    key = 16'h0; repeat (D + 4) step();
    chk("rep_count", idx.size(), 3);
    if (idx.size() == 3) begin
      chk("rep_first", idx[0], 5);
      chk("rep_second", idx[1], 55);
      chk("rep_third", idx[2], 105);
    end
    key = 16'h0004;
    repeat (30) step();
    reset = 1'b0;
    #1;
    chk("reprst_digits", digits, 32'h0);
    chk("reprst_ndigits", 32'(ndigits), 32'h0);
    chk("reprst_code", 32'(key_code), 32'h0);
    chk("reprst_full", 32'(full), 32'h0);
    step();
    reset = 1'b1; key = 16'h0;
    repeat (D + 4) step();
`endif

    // Randomized traffic against the model
    hold = 0;
    for (int i = 0; i < 2500; i++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2:       key = 16'h0;
          3, 4, 5, 6, 7: key = 16'(1 << $urandom_range(0, 15));
          default:       key = 16'($urandom);
        endcase
        hold = $urandom_range(1, 12);
      end
      hold--;
      clr   = ($urandom_range(0, 59) == 0);
      bksp  = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 399) != 0);
      step();
    end
    key = 16'h0; clr = 1'b0; bksp = 1'b0; reset = 1'b1;
    repeat (10) step();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/keypad_entry_ctrl.md
KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 3: consecutive stable cycles required to accept a press or release.
REQ-002 Parameter REPEAT_CYC, default 50: hold cycles between auto-repeats (used only with KEYPAD_AUTOREPEAT_EN).
REQ-003 hz100  in  1: sole clock; all state updates on rising edge.
REQ-004 reset  in  1: asynchronous, active-low reset.
REQ-005 key  in  16: raw, asynchronous push-button levels; bit i = hex digit i.
REQ-006 clr  in  1: synchronous single-cycle pulse; empties the digit buffer.
REQ-007 bksp  in  1: synchronous single-cycle pulse; removes the newest digit.
REQ-008 key_code  out  4: code of the last accepted key, held until the next acceptance.
REQ-009 key_strobe  out  1: one-cycle pulse per accepted key event.
REQ-010 digits  out  32: eight 4-bit digits; [3:0] is the newest digit.
REQ-011 ndigits  out  4: number of valid digits, 0..8.
REQ-012 full  out  1: high while ndigits == 8.
REQ-013 overflow  out  1: one-cycle pulse when a key is accepted while full.

Function
REQ-014 key SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 The synchronized vector SHALL be priority-encoded so that the highest set index wins; a valid flag SHALL indicate any bit set.
REQ-016 The FSM SHALL implement the states IDLE, DEBOUNCE, HELD and RELEASE.
REQ-017 IDLE -> DEBOUNCE when valid; the candidate code SHALL be latched and the counter cleared.
REQ-018 In DEBOUNCE, a changed code SHALL re-latch the candidate and restart the count, and loss of valid SHALL return the FSM to IDLE.
REQ-019 In DEBOUNCE, when the count reaches DEBOUNCE_CYC the FSM SHALL pulse key_strobe, update key_code, and go to HELD.
REQ-020 Latency: a key held stable from edge k SHALL produce key_strobe high in cycle k+2+DEBOUNCE_CYC.
REQ-021 HELD -> RELEASE when valid drops; a different code while in HELD SHALL be ignored.
REQ-022 In RELEASE, DEBOUNCE_CYC consecutive cycles with valid low SHALL lead to IDLE; valid returning high SHALL lead back to HELD with no strobe.
REQ-023 Acceptance with ndigits < 8: digits SHALL become {digits[27:0], code} and ndigits SHALL increment.
REQ-024 Acceptance with ndigits == 8: digits SHALL be unchanged, and key_strobe and overflow SHALL both pulse.
REQ-025 bksp with ndigits > 0: digits SHALL become {4'h0, digits[31:4]} and ndigits SHALL decrement.
REQ-026 bksp with ndigits == 0: no effect.
REQ-027 clr SHALL zero digits and ndigits.
REQ-028 Same-cycle priority: clr > bksp > acceptance; a losing acceptance SHALL still pulse key_strobe and SHALL NOT modify the buffer.

Reset
REQ-029 While reset is low, state = IDLE, counters = 0, synchronizer = 0, and all outputs = 0.
REQ-030 Reset asserted mid-press SHALL abort the press with no strobe; after release of reset, a still-held key SHALL re-debounce from IDLE.

Configuration
REQ-031 With KEYPAD_AUTOREPEAT_EN defined: in HELD, every REPEAT_CYC cycles SHALL generate a further acceptance of the held code, with the full REQ-023/024 effects.
REQ-032 Without KEYPAD_AUTOREPEAT_EN defined: HELD SHALL never re-strobe, and no repeat counter SHALL be synthesized.

Structure
REQ-033 Package keypad_pkg SHALL hold the state enum, NDIGITS = 8, and DIGIT_W = 4.
REQ-034 The priority encoder SHALL be a separate sub-module, key_prienc, with inputs in[15:0] and outputs code[3:0] and valid.

Verification
REQ-035 Hold key[5] for 10 cycles after reset -> single key_strobe at cycle 5, key_code = 5, digits = 0x00000005, ndigits = 1.
REQ-036 key = 0x8041 stable -> key_code = 0xF; key[15] glitching 1 cycle in DEBOUNCE -> count restarts, exactly one strobe.
REQ-037 Enter 1..8, then press 9 -> digits = 0x12345678, full = 1, and overflow pulses on press 9 with digits unchanged.
REQ-038 From digits = 0x12345678: bksp -> 0x01234567, ndigits = 7; clr and an acceptance in the same cycle -> digits = 0, ndigits = 0, key_strobe = 1.
REQ-039 Release bounce (valid low 1 cycle, then high) in RELEASE -> returns to HELD, no second strobe.
REQ-040 With KEYPAD_AUTOREPEAT_EN defined: hold key[2] for 120 cycles -> strobes at cycles 5, 55 and 105; reset low at cycle 30 -> all outputs 0 immediately.
